lru_slot_arbiter: RTL and testbench
===================================

Name: lru_slot_arbiter

Overview:
- Shares NUM_SLOTS resource slots (lamps/channels) among NUM_REQ requesters.
- A request is admitted after it has been held for HOLD_TICKS timer ticks.
- When every slot is busy, the least-recently-used holder is evicted to make room.
- Sits between the debounced button/requester inputs and the LRU lamp datapath; the timer block supplies the tick strobe.

Parameters:
- NUM_REQ, 4, number of requesters.
- NUM_SLOTS, 3, number of simultaneously grantable slots; must be less than NUM_REQ.
- HOLD_TICKS, 2, ticks a request must be held before it qualifies (1..15).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low; rst=0 at a clk rising edge clears all state.
- tick  in  1  one-clk-wide strobe from the timer, in the clk domain.
- req  in  NUM_REQ  level request per requester.
- rel  in  NUM_REQ  level release per requester; held until gnt[i]=0.
- gnt  out  NUM_REQ  slot granted per requester.
- evict_valid  out  1  one-cycle pulse when a holder is evicted.
- evict_id  out  $clog2(NUM_REQ)  id of the evicted requester; valid only with evict_valid.
- full  out  1  granted count equals NUM_SLOTS.

Behaviour:
- Reset (rst=0):
  - gnt=0, evict_valid=0, evict_id=0, full=0.
  - All hold counters 0, recency list empty, FSM in S_IDLE.
  - Reset mid-operation (any state) aborts the operation; no evict pulse is emitted.
- Hold counter per requester (4-bit):
  - On tick with req[i]=1 and gnt[i]=0: increment, saturating at HOLD_TICKS.
  - req[i]=0 in any cycle: counter cleared.
  - Requester i is qualified when counter==HOLD_TICKS and gnt[i]=0.
- Touch: on tick in S_IDLE with req[i]=1 and gnt[i]=1, i moves to the MRU end of the recency list. Only one touch per tick: the lowest index wins.
- FSM states: S_IDLE, S_EVICT, S_GRANT.
- S_IDLE, evaluated in order each cycle:
  - (a) Release: every i with rel[i]=1 and gnt[i]=1 has gnt[i] cleared next cycle and is removed from the list. rel on a non-granted requester is ignored.
  - (b) Admission: on tick, the lowest-index qualified requester becomes the candidate. Occupancy after the releases in (a) decides the path:
    - occupancy < NUM_SLOTS: go to S_GRANT.
    - otherwise: go to S_EVICT.
  - (c) A touch and an admission may occur in the same tick. The touch is applied first.
- S_EVICT, one cycle:
  - Clear gnt of the LRU (list head) and remove it from the list.
  - evict_valid=1 and evict_id=that id in this cycle.
  - Then go to S_GRANT.
- S_GRANT, one cycle:
  - Set gnt[candidate], append candidate at the MRU end, clear its hold counter.
  - Then go to S_IDLE.
- Latency from the qualifying tick edge:
  - gnt rises 2 clk later when not full.
  - gnt rises 3 clk later when full; evict_valid appears 1 clk before gnt.
- Inputs ignored outside S_IDLE: rel, tick-driven admissions, and touches are not acted on in S_EVICT/S_GRANT. Counters still advance. req and rel are levels, so nothing is lost.
- Candidate drops req during S_EVICT or S_GRANT: the grant still completes. The requester must release explicitly.
- Invariants:
  - full = (popcount(gnt)==NUM_SLOTS), registered.
  - popcount(gnt) never exceeds NUM_SLOTS.
  - List length always equals popcount(gnt).

Decomposition:
- Package lru_pkg holds:
  - state_t enum {S_IDLE, S_EVICT, S_GRANT}.
  - Default localparams NUM_REQ and NUM_SLOTS.
  - req_id_t (logic [$clog2(NUM_REQ)-1:0]).
- Sub-module lru_order: the NUM_SLOTS-deep recency list of req_id_t.
  - Operations: push_mru, touch(id), remove(id), remove_head.
  - Outputs: head id and count.
  - One operation per cycle; remove takes priority over touch.

Test Plan:
- Reset: rst=0 with req=4'b1111 for 2 clk -> gnt=0000, full=0, evict_valid=0. Release rst, hold req=0001 for 1 tick -> gnt stays 0000.
- Admission: req=0001 for 2 ticks -> gnt=0001 two clk after the 2nd tick. Then req=0010 for 2 ticks -> gnt=0011. Then req=0100 for 2 ticks -> gnt=0111, full=1.
- Eviction: from gnt=0111 with order 0,1,2, qualify req=1000 -> evict_valid=1 with evict_id=0, then gnt=1110 one clk later.
- Touch changes the victim: from gnt=0111 (order 0,1,2), tick with req=0001 (touch 0), then qualify requester 3 -> evict_id=1, gnt=1101.
- Release before admission: gnt=0111, rel=0010 held in the same cycle as requester 3's qualifying tick -> no evict_valid, gnt=1101, full=1.
- Simultaneous qualify: requesters 1 and 3 qualify on the same tick with 1 slot free -> gnt[1] set first. Requester 3 is admitted on the next tick via eviction of the LRU.

Source files
------------

// File: rtl/lru_pkg.sv
// lru_pkg: shared types and default sizes for the LRU slot arbiter
package lru_pkg;
  localparam int NUM_REQ = 4;
  localparam int NUM_SLOTS = 3;
  typedef enum logic [1:0] {S_IDLE, S_EVICT, S_GRANT} state_t;
  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;
endpackage

// File: rtl/lru_order.sv
// lru_order: recency list of slot holders, head is least recently used
module lru_order #(
  parameter int NUM_REQ = 4,
  parameter int NUM_SLOTS = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [$clog2(NUM_REQ)-1:0]     push_id_i,
  input  logic                           touch_i,
  input  logic [$clog2(NUM_REQ)-1:0]     touch_id_i,
  input  logic [NUM_REQ-1:0]             remove_i,
  input  logic                           pop_head_i,
  output logic [$clog2(NUM_REQ)-1:0]     head_o,
  output logic [$clog2(NUM_SLOTS+1)-1:0] count_o
);
  import lru_pkg::*;
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(NUM_SLOTS + 1);
  logic [IW-1:0] ids_q [NUM_SLOTS];
  logic [IW-1:0] ids_d [NUM_SLOTS];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] rm;
  logic app;
  // every operation is "drop a set of ids, compact, optionally append at MRU"
  always_comb begin
    rm = |remove_i ? remove_i
       : pop_head_i ? NUM_REQ'(1) << ids_q[0]
       : touch_i ? NUM_REQ'(1) << touch_id_i : '0;
    app = push_i || (touch_i && !(|remove_i) && !pop_head_i);
    ids_d = ids_q;
    cnt_d = '0;
    for (int k = 0; k < NUM_SLOTS; k++)
      if (CW'(k) < cnt_q && !rm[ids_q[k]]) begin
        ids_d[cnt_d] = ids_q[k];
        cnt_d = cnt_d + 1'b1;
      end
    if (app && cnt_d < CW'(NUM_SLOTS)) begin
      ids_d[cnt_d] = push_i ? push_id_i : touch_id_i;
      cnt_d = cnt_d + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      ids_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      ids_q <= ids_d;
      cnt_q <= cnt_d;
    end
  assign head_o = ids_q[0];
  assign count_o = cnt_q;
endmodule

// File: rtl/lru_slot_arbiter.sv
// lru_slot_arbiter: admits held requests onto a few shared slots,
// evicting the least recently used holder when every slot is busy
module lru_slot_arbiter #(
  parameter int NUM_REQ = lru_pkg::NUM_REQ,
  parameter int NUM_SLOTS = lru_pkg::NUM_SLOTS,
  parameter int HOLD_TICKS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         rel,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       evict_valid,
  output logic [$clog2(NUM_REQ)-1:0] evict_id,
  output logic                       full
);
  import lru_pkg::*;
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam int OW = $clog2(NUM_REQ + 1);
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, rel_m, qual, held;
  logic [3:0] cnt_q [NUM_REQ];
  logic [3:0] cnt_d [NUM_REQ];
  logic [IW-1:0] cand_q, cand_d, first, tch_id, head, evict_id_q;
  logic [CW-1:0] lst_cnt;
  logic [OW-1:0] occ;
  logic adm, tch, evict_valid_q, full_q;
  function automatic logic [OW-1:0] pop(input logic [NUM_REQ-1:0] v);
    pop = '0;
    for (int i = 0; i < NUM_REQ; i++) pop = pop + OW'(v[i]);
  endfunction
  // qualification looks at the post-tick count so the saturating tick itself admits
  always_comb begin
    rel_m = (state_q == S_IDLE) ? rel & gnt_q : '0;
    held = req & gnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = !req[i] ? 4'd0
               : (tick && !gnt_q[i] && cnt_q[i] != 4'(HOLD_TICKS)) ? cnt_q[i] + 4'd1 : cnt_q[i];
      qual[i] = !gnt_q[i] && cnt_d[i] == 4'(HOLD_TICKS);
    end
    first = '0;
    tch_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (qual[i]) first = IW'(i);
      if (held[i]) tch_id = IW'(i);
    end
    adm = state_q == S_IDLE && tick && |qual;
    tch = state_q == S_IDLE && tick && |held;
    occ = OW'(lst_cnt) - pop(rel_m);
    state_d = state_q;
    gnt_d = gnt_q & ~rel_m;
    cand_d = adm ? first : cand_q;
    if (adm) state_d = occ < OW'(NUM_SLOTS) ? S_GRANT : S_EVICT;
    if (state_q == S_EVICT) begin
      gnt_d[head] = 1'b0;
      state_d = S_GRANT;
    end
    if (state_q == S_GRANT) begin
      gnt_d[cand_q] = 1'b1;
      cnt_d[cand_q] = 4'd0;
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q <= '0;
      cand_q <= '0;
      cnt_q <= '{default: '0};
      evict_valid_q <= 1'b0;
      evict_id_q <= '0;
      full_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      evict_valid_q <= state_q == S_EVICT;
      evict_id_q <= state_q == S_EVICT ? head : evict_id_q;
      full_q <= pop(gnt_d) == OW'(NUM_SLOTS);
    end
  lru_order #(.NUM_REQ(NUM_REQ), .NUM_SLOTS(NUM_SLOTS)) u_order (
    .clk        (clk),
    .rst        (rst),
    .push_i     (state_q == S_GRANT),
    .push_id_i  (cand_q),
    .touch_i    (tch),
    .touch_id_i (tch_id),
    .remove_i   (rel_m),
    .pop_head_i (state_q == S_EVICT),
    .head_o     (head),
    .count_o    (lst_cnt)
  );
  assign gnt = gnt_q;
  assign evict_valid = evict_valid_q;
  assign evict_id = evict_id_q;
  assign full = full_q;
endmodule

// File: tb/tb_lru_slot_arbiter.sv
// tb_lru_slot_arbiter: directed scenarios for admission, eviction, touch and release
module tb_lru_slot_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] rel = '0;
  logic [3:0] gnt;
  logic evict_valid;
  logic [1:0] evict_id;
  logic full;
  int checks = 0;
  int failures = 0;

  lru_slot_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .req         (req),
    .rel         (rel),
    .gnt         (gnt),
    .evict_valid (evict_valid),
    .evict_id    (evict_id),
    .full        (full)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    rel = '0;
    tick = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic admit(input logic [3:0] m);
    req = m;
    pulse();
    cyc();
    pulse();
    cyc();
    req = '0;
  endtask

  task automatic setup_three();
    do_reset();
    admit(4'b0001);
    admit(4'b0010);
    admit(4'b0100);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'b1111;
    cyc();
    cyc();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (evict_valid !== 1'b0) begin failures++; $display("FAIL reset_evict got=%b exp=0", evict_valid); end
    checks++; if (evict_id !== 2'd0) begin failures++; $display("FAIL reset_evict_id got=%0d exp=0", evict_id); end
    rst = 1'b1;
    req = 4'b0001;
    pulse();
    cyc();
    cyc();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL one_tick_gnt got=%b exp=0000", gnt); end
    req = '0;
    cyc();
  endtask

  task automatic test_admission();
    req = 4'b0001;
    pulse();
    cyc();
    pulse();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL adm_early got=%b exp=0000", gnt); end
    cyc();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL adm_first got=%b exp=0001", gnt); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL adm_first_full got=%b exp=0", full); end
    req = '0;
    admit(4'b0010);
    checks++; if (gnt !== 4'b0011) begin failures++; $display("FAIL adm_second got=%b exp=0011", gnt); end
    admit(4'b0100);
    checks++; if (gnt !== 4'b0111) begin failures++; $display("FAIL adm_third got=%b exp=0111", gnt); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL adm_full got=%b exp=1", full); end
  endtask

  task automatic test_eviction();
    req = 4'b1000;
    pulse();
    cyc();
    pulse();
    checks++; if (evict_valid !== 1'b0 || gnt !== 4'b0111) begin failures++; $display("FAIL ev_pre got=%b/%b exp=0/0111", evict_valid, gnt); end
    cyc();
    checks++; if (evict_valid !== 1'b1) begin failures++; $display("FAIL ev_valid got=%b exp=1", evict_valid); end
    checks++; if (evict_id !== 2'd0) begin failures++; $display("FAIL ev_id got=%0d exp=0", evict_id); end
    checks++; if (gnt !== 4'b0110) begin failures++; $display("FAIL ev_mid_gnt got=%b exp=0110", gnt); end
    cyc();
    checks++; if (gnt !== 4'b1110) begin failures++; $display("FAIL ev_gnt got=%b exp=1110", gnt); end
    checks++; if (evict_valid !== 1'b0) begin failures++; $display("FAIL ev_pulse_len got=%b exp=0", evict_valid); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ev_full got=%b exp=1", full); end
    req = '0;
  endtask

  task automatic test_touch();
    setup_three();
    req = 4'b0001;
    pulse();
    req = 4'b1000;
    pulse();
    cyc();
    pulse();
    cyc();
    checks++; if (evict_valid !== 1'b1 || evict_id !== 2'd1) begin failures++; $display("FAIL touch_victim got=%b/%0d exp=1/1", evict_valid, evict_id); end
    cyc();
    checks++; if (gnt !== 4'b1101) begin failures++; $display("FAIL touch_gnt got=%b exp=1101", gnt); end
    req = '0;
  endtask

  task automatic test_release();
    setup_three();
    req = 4'b1000;
    pulse();
    cyc();
    rel = 4'b0010;
    pulse();
    checks++; if (gnt !== 4'b0101) begin failures++; $display("FAIL rel_gnt got=%b exp=0101", gnt); end
    rel = '0;
    checks++; if (evict_valid !== 1'b0) begin failures++; $display("FAIL rel_evict1 got=%b exp=0", evict_valid); end
    cyc();
    checks++; if (evict_valid !== 1'b0) begin failures++; $display("FAIL rel_evict2 got=%b exp=0", evict_valid); end
    checks++; if (gnt !== 4'b1101) begin failures++; $display("FAIL rel_admit got=%b exp=1101", gnt); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL rel_full got=%b exp=1", full); end
    req = '0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    admit(4'b0001);
    admit(4'b0100);
    req = 4'b1010;
    pulse();
    cyc();
    pulse();
    cyc();
    checks++; if (gnt !== 4'b0111) begin failures++; $display("FAIL sim_low_first got=%b exp=0111", gnt); end
    checks++; if (evict_valid !== 1'b0) begin failures++; $display("FAIL sim_no_evict got=%b exp=0", evict_valid); end
    cyc();
    cyc();
    checks++; if (gnt !== 4'b0111) begin failures++; $display("FAIL sim_wait_tick got=%b exp=0111", gnt); end
    pulse();
    cyc();
    checks++; if (evict_valid !== 1'b1 || evict_id !== 2'd0) begin failures++; $display("FAIL sim_victim got=%b/%0d exp=1/0", evict_valid, evict_id); end
    cyc();
    checks++; if (gnt !== 4'b1110) begin failures++; $display("FAIL sim_gnt got=%b exp=1110", gnt); end
    req = '0;
  endtask

  task automatic test_mid_reset();
    setup_three();
    req = 4'b1000;
    pulse();
    cyc();
    pulse();
    rst = 1'b0;
    req = '0;
    cyc();
    checks++; if (evict_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_evict got=%b exp=0", evict_valid); end
    checks++; if (gnt !== 4'b0000 || full !== 1'b0) begin failures++; $display("FAIL mid_rst_state got=%b/%b exp=0000/0", gnt, full); end
    cyc();
    checks++; if (evict_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_late got=%b exp=0", evict_valid); end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_admission();
    test_eviction();
    test_touch();
    test_release();
    test_simultaneous();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
